// File: rtl/ifm_skew_feeder.sv
// ifm_skew_feeder
// Left-border input feeder for the systolic array. Accepts one column of
// HEIGHT signed activations per cycle (valid/ready), skews row h by h cycles
// to form the wavefront, and tracks the drain of each tile with a small FSM.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready column handshake (in_ready is a registered state flag)
//   in_last           last column of the tile, qualified by in_valid
//   in_data           packed column, row h = in_data[h*IWIDTH +: IWIDTH]
//   ifm[h]            per-row activation to the array
//   en_i[h], clr_i[h] per-row element-valid and first-of-tile clear
//   busy              high in STREAM, DRAIN and DONE
//   done              one-cycle pulse once the last element left row HEIGHT-1
//
// Build option: define FEEDER_ZERO_BUBBLE_EN to present zero data on bubble
// cycles; otherwise bubbles carry whatever in_data held.
module ifm_skew_feeder #(
  parameter int HEIGHT = 12,
  parameter int IWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [HEIGHT*IWIDTH-1:0]   in_data,
  output logic signed [IWIDTH-1:0]   ifm [HEIGHT],
  output logic [HEIGHT-1:0]          en_i,
  output logic [HEIGHT-1:0]          clr_i,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             first;
  logic             accept;

  assign accept = in_valid && in_ready;

  // Tile FSM. in_ready, busy and done are registered alongside the state so
  // that every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      first    <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            first    <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= in_last ? DRAIN : STREAM;
            in_ready <= !in_last;
          end
        end
        STREAM: begin
          if (accept) begin
            first <= 1'b0;
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              cnt      <= '0;
            end
          end
        end
        DRAIN: begin
          if (cnt == CNT_W'(HEIGHT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          first    <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skew rows: row h is a shift register of h+1 {data, vld, clr} stages.
  // Data is cleared on reset as well, since ifm must read zero after reset.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    logic signed [IWIDTH-1:0] data_p [h+1];
    logic                     vld_p  [h+1];
    logic                     clr_p  [h+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= h; s++) begin
          data_p[s] <= '0;
          vld_p[s]  <= 1'b0;
          clr_p[s]  <= 1'b0;
        end
      end else begin
        // stage 0: capture the incoming column slice
`ifdef FEEDER_ZERO_BUBBLE_EN
        data_p[0] <= accept ? in_data[h*IWIDTH +: IWIDTH] : '0;
`else
        data_p[0] <= in_data[h*IWIDTH +: IWIDTH];
`endif
        vld_p[0] <= accept;
        clr_p[0] <= accept && first;
        // stages 1..h: unconditional shift, no backpressure from the array
        for (int s = 1; s <= h; s++) begin
          data_p[s] <= data_p[s-1];
          vld_p[s]  <= vld_p[s-1];
          clr_p[s]  <= clr_p[s-1];
        end
      end
    end

    assign ifm[h]   = data_p[h];
    assign en_i[h]  = vld_p[h];
    assign clr_i[h] = clr_p[h];
  end

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Testbench for ifm_skew_feeder (HEIGHT=4, IWIDTH=8). The stimulus process
// records every accepted column with its acceptance edge; a separate monitor
// derives, each cycle, what every row, done, busy and in_ready must show from
// those records and the tile boundaries.
module tb_ifm_skew_feeder;
  localparam int H  = 4;
  localparam int W  = 8;
  localparam int BIG = 1 << 30;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  in_last = 1'b0;
  logic [H*W-1:0]        in_data = '0;
  logic signed [W-1:0]   ifm [H];
  logic [H-1:0]          en_i;
  logic [H-1:0]          clr_i;
  logic                  busy;
  logic                  done;

  ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data), .ifm(ifm), .en_i(en_i),
    .clr_i(clr_i), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    logic [31:0] data;
    bit          clr;
  } col_t;

  col_t q[$];
  int   dq[$];
  int   tile_start = -100;
  int   tile_end   = -100;
  int   rst_until  = 0;
  bit   first_m    = 1'b1;
  bit   chk_en     = 1'b0;
  int   n_cmp      = 0;
  int   n_bad      = 0;

  function automatic bit exp_ready(input int c);
    return (c > rst_until) && !(c > tile_end && c <= tile_end + H + 1);
  endfunction

  function automatic logic [31:0] col4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string name, input int h, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row%0d cycle %0d: got %0d, expected %0d", name, h, cyc, act, exp);
    end
  endtask

  task automatic flush_model();
    q.delete();
    dq.delete();
    tile_start = -100;
    tile_end   = -100;
    first_m    = 1'b1;
  endtask

  task automatic record(input int c, input bit l, input logic [31:0] d);
    col_t e;
    e.t = c; e.data = d; e.clr = first_m;
    q.push_back(e);
    if (first_m) begin
      tile_start = c;
      tile_end   = BIG;
    end
    first_m = 1'b0;
    if (l) begin
      tile_end = c;
      dq.push_back(c + H + 1);
      first_m = 1'b1;
    end
  endtask

  task automatic drive(input bit v, input bit l, input logic [31:0] d);
    @(posedge clk); #1;
    in_valid = v; in_last = l; in_data = d;
    @(negedge clk);
    if (v && exp_ready(cyc)) record(cyc, l, d);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        flush_model();
        rst_until = cyc;
      end
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    flush_model();
    rst_until = cyc;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom);
  endtask

  // Monitor: every cycle, each row must show exactly the column accepted
  // h+1 edges earlier, or a bubble.
  always @(negedge clk) begin
    if (chk_en) begin
      bit          e_en;
      bit          e_clr;
      logic [31:0] e_d;
      bit          e_done;
      while (q.size() > 0 && q[0].t < cyc - H) void'(q.pop_front());
      for (int h = 0; h < H; h++) begin
        e_en = 1'b0; e_clr = 1'b0; e_d = '0;
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].t == cyc - 1 - h) begin
            e_en = 1'b1; e_clr = q[k].clr; e_d = q[k].data;
          end
        end
        chk("en_i", h, int'(en_i[h]), int'(e_en));
        chk("clr_i", h, int'(clr_i[h]), int'(e_clr));
        if (e_en) chk("ifm", h, int'(ifm[h]), int'($signed(e_d[h*W +: W])));
`ifdef FEEDER_ZERO_BUBBLE_EN
        else chk("ifm_bubble", h, int'(ifm[h]), 0);
`endif
        if (cyc == rst_until) chk("ifm_reset", h, int'(ifm[h]), 0);
      end
      e_done = (dq.size() > 0 && dq[0] == cyc);
      chk("done", 0, int'(done), int'(e_done));
      while (dq.size() > 0 && dq[0] <= cyc) void'(dq.pop_front());
      chk("in_ready", 0, int'(in_ready), int'(exp_ready(cyc)));
      chk("busy", 0, int'(busy),
          int'(cyc > tile_start && cyc <= tile_end + H + 1));
    end
  end

  initial begin
    do_reset(3);
    idle(3);
    // three back-to-back columns, last on the third
    drive(1'b1, 1'b0, col4(1, 2, 3, 4));
    drive(1'b1, 1'b0, col4(5, 6, 7, 8));
    drive(1'b1, 1'b1, col4(-1, -2, -3, -4));
    idle(8);
    // valid gap with random data on the bubble
    drive(1'b1, 1'b0, col4(11, 12, 13, 14));
    drive(1'b0, 1'b1, 32'hA5C3_7E91);
    drive(1'b1, 1'b1, col4(-21, -22, -23, -24));
    idle(8);
    // single-column tile, valid held through drain
    drive(1'b1, 1'b1, col4(10, 20, 30, 40));
    for (int i = 0; i < H + 1; i++) drive(1'b1, 1'b0, $urandom);
    idle(3);
    // reset mid-tile, then a fresh tile
    drive(1'b1, 1'b0, col4(-128, 127, 1, -1));
    drive(1'b1, 1'b0, col4(3, 3, 3, 3));
    drive(1'b1, 1'b0, col4(9, 9, 9, 9));
    do_reset(1);
    drive(1'b1, 1'b1, col4(7, -7, 7, -7));
    idle(8);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) do_reset(1 + $urandom_range(1));
      else drive($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom);
    end
    idle(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifm_skew_feeder.md
# ifm_skew_feeder

Input-side feeder for the binary-parallel systolic array. It accepts one column of HEIGHT activations per cycle over a valid/ready handshake. It delays row h by h cycles to form the systolic wavefront, and drives the per-row `ifm`, `en_i` and `clr_i` inputs of the array's left border. A tile-level FSM tracks the wavefront drain after the last vector, so downstream control knows when the array has seen every activation of a tile.

## Interface
- `HEIGHT`, 12, number of array rows (skew depth is HEIGHT-1).
- `IWIDTH`, 8, activation width in bits, signed two's complement.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `in_valid` input 1 — `in_data` holds a valid activation column.
- `in_ready` output 1 — feeder can accept a column this cycle.
- `in_last` input 1 — the column is the last of the current tile; qualified by `in_valid`.
- `in_data` input HEIGHT*IWIDTH — packed column; row h is `in_data[h*IWIDTH +: IWIDTH]`.
- `ifm` output HEIGHT x IWIDTH, signed — per-row activation to the array's left border.
- `en_i` output HEIGHT — per-row enable; high when `ifm[h]` carries a valid element.
- `clr_i` output HEIGHT — per-row clear; high with the first element of a tile at that row.
- `busy` output 1 — high in STREAM, DRAIN and DONE.
- `done` output 1 — one-cycle pulse when the last element of a tile has left row HEIGHT-1.

## Operation
- A column is accepted on cycle t when `in_valid && in_ready`.
- Per-row skew pipeline: row h has h+1 register stages of {data, en, clr}. The final stage drives `ifm[h]`, `en_i[h]` and `clr_i[h]`.
  - Stage 0 loads {`in_data` slice, accept, accept && first} every cycle.
  - All stages shift every cycle; there is no backpressure from the array.
  - A cycle without an accept inserts a bubble (en=0, clr=0) that propagates down each row.
- `first` is an internal flag. It is set in IDLE and after DONE, and cleared by the first accept of a tile. Only the first column of a tile carries clr=1.
- FSM states:
  - IDLE: `in_ready`=1. An accept moves to STREAM, or to DRAIN if `in_last` is also set.
  - STREAM: `in_ready`=1. An accept with `in_last` moves to DRAIN.
  - DRAIN: `in_ready`=0. An internal counter runs from 0 to HEIGHT-1; at count HEIGHT-1 the FSM moves to DONE.
  - DONE: `in_ready`=0, `done`=1 for exactly one cycle, then IDLE.
- A single-column tile (first and last on the same accept) carries clr=1 and en=1 on that column and then drains normally.
- HEIGHT=1: DRAIN lasts exactly 1 cycle.
- `in_last` without `in_valid` is ignored.
- No arithmetic: data passes bit-exact with sign preserved.

## Timing
- Reset values: `ifm`=0 (all rows), `en_i`=0, `clr_i`=0, `in_ready`=0 during reset, `busy`=0, `done`=0; FSM=IDLE, `first`=1, all skew stages cleared. `in_ready`=1 from the first cycle after reset deassertion.
- Latency: a column accepted at edge t appears at row h on cycle t+1+h.
- The last column accepted at edge t gives:
  - DRAIN on cycles t+1 .. t+HEIGHT;
  - row HEIGHT-1 presents the last element on cycle t+HEIGHT;
  - `done` high on cycle t+HEIGHT+1;
  - IDLE with `in_ready`=1 on cycle t+HEIGHT+2.
- Minimum gap from the last accept of one tile to the first accept of the next is HEIGHT+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs except `in_ready`, which depends only on the FSM state.
- Reset mid-tile: on the next edge, all in-flight elements are discarded, outputs return to reset values, and no `done` pulse is generated.

## Configuration
- `FEEDER_ZERO_BUBBLE_EN` defined: `ifm[h]` is forced to 0 whenever `en_i[h]`=0, so bubbles present zero data to the array.
- Not defined: the data stage loads `in_data` unconditionally, so bubbles carry whatever `in_data` held.
- `en_i`, `clr_i` and all timing are identical in both builds.

## Test plan
All scenarios use HEIGHT=4, IWIDTH=8.
- Reset release, idle: `ifm`=0, `en_i`=4'b0000, `clr_i`=4'b0000, `in_ready`=1, `busy`=0, `done`=0.
- Three back-to-back columns {rows 0..3} = {1,2,3,4}, {5,6,7,8}, {-1,-2,-3,-4}, last on the third, first accept at edge 0:
  - `ifm[0]`=1,5,-1 on cycles 1..3;
  - `ifm[3]`=4,8,-4 on cycles 4..6;
  - `clr_i[h]` high only on cycle 1+h;
  - `done` on cycle 7; `in_ready`=1 on cycle 8.
- Valid gap: columns at edges 0 and 2, nothing at edge 1. `en_i[2]`=1,0,1 on cycles 3,4,5. With `FEEDER_ZERO_BUBBLE_EN`, `ifm[2]`=0 on cycle 4.
- Single-column tile {10,20,30,40} with `in_last`: `en_i[h]` and `clr_i[h]` both high on cycle 1+h; `done` on cycle 5; `in_valid` held high during DRAIN is not accepted.
- `rst` asserted on cycle 3 mid-tile: cycle 4 shows all outputs at reset values; no `done` pulse; a new tile starting after reset gets `clr_i[0]`=1.
